// File: rtl/prog_clk_divider_pkg.sv
// Shared definitions for the programmable clock divider.
//   DIV_W           default width of the period/high counters and config fields
//   DIV_DEF_PERIOD  default period after reset
//   clamp_cfg()     legalises a requested (period, high) pair and flags any change
package div_pkg;

    localparam int DIV_W          = 16;
    localparam int DIV_DEF_PERIOD = 10;

    typedef logic [DIV_W-1:0] cfg_word_t;

    typedef struct packed {
        cfg_word_t period;
        cfg_word_t high;
        logic      err;
    } clamp_t;

    // Period below 2 cannot produce both a high and a low phase; a high time
    // of zero or one that fills the whole period would stop the clock, so it
    // falls back to half the (already legalised) period.
    function automatic clamp_t clamp_cfg(input cfg_word_t p, input cfg_word_t h);
        clamp_t r;
        r.period = p;
        r.high   = h;
        r.err    = 1'b0;
        if (p < cfg_word_t'(2)) begin
            r.period = cfg_word_t'(2);
            r.err    = 1'b1;
        end
        if ((h == '0) || (h >= r.period)) begin
            r.high = r.period >> 1;
            r.err  = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prog_clk_divider_if.sv
// Configuration handshake between a config source and the divider.
//   cfg_valid   source offers a new period/high pair
//   cfg_period  requested period P
//   cfg_high    requested high time H
//   cfg_ready   divider shadow is empty and can take a new pair
//   cfg_err     one-cycle pulse: the accepted pair was clamped
// master: config source side, slave: divider side.
interface prog_clk_divider_if
    import div_pkg::*;
#(
    parameter int W = DIV_W
);
    logic         cfg_valid;
    logic [W-1:0] cfg_period;
    logic [W-1:0] cfg_high;
    logic         cfg_ready;
    logic         cfg_err;

    modport master (
        output cfg_valid, cfg_period, cfg_high,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_period, cfg_high,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/prog_clk_divider_cfg_shadow.sv
// Config shadow for the divider: takes a new period/high pair over the
// handshake, clamps it, holds it until the divider applies it.
//   clk, reset   clock and synchronous active-high reset
//   cfg          handshake (slave side): drives cfg_ready and cfg_err
//   apply_evt    divider is at a point where a pending pair may be applied
//   pend         shadow holds a pair not yet applied
//   sh_period    clamped period held in the shadow
//   sh_high      clamped high time held in the shadow
// W must equal div_pkg::DIV_W, the width the clamp function works at.
module div_cfg_shadow
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic                clk,
    input  logic                reset,
    prog_clk_divider_if.slave   cfg,
    input  logic                apply_evt,
    output logic                pend,
    output logic [W-1:0]        sh_period,
    output logic [W-1:0]        sh_high
);

    logic   accept;
    clamp_t cl;

    // Ready only while empty, so an accept never coincides with an apply:
    // a pair taken on a wrap edge waits for the following wrap.
    assign cfg.cfg_ready = ~pend;
    assign accept        = cfg.cfg_valid & ~pend;

    always_comb begin
        cl = clamp_cfg(cfg.cfg_period, cfg.cfg_high);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend        <= 1'b0;
            cfg.cfg_err <= 1'b0;
        end else begin
            cfg.cfg_err <= accept & cl.err;
            if (accept) begin
                pend <= 1'b1;
            end else if (apply_evt) begin
                pend <= 1'b0;
            end
        end
    end

    // Shadow contents are meaningful only while pend is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            sh_period <= cl.period;
            sh_high   <= cl.high;
        end
    end

endmodule

// File: rtl/prog_clk_divider.sv
// Runtime-programmable clock divider with period P and high time H in clk
// cycles. New P/H pairs take effect glitch-free at a period boundary, while
// idle, or on resync.
//   clk     single clock, all logic on posedge
//   reset   synchronous, active-high
//   en      count enable; low freezes counter and out
//   resync  one-cycle request to restart the period at phase 0
//   cfg     config handshake (slave side)
//   out     divided clock, registered
//   tick    one-cycle pulse with each rising period start of out
module prog_clk_divider
    import div_pkg::*;
#(
    parameter int W          = DIV_W,
    parameter int DEF_PERIOD = DIV_DEF_PERIOD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              resync,
    prog_clk_divider_if.slave cfg,
    output logic              out,
    output logic              tick
);

    localparam logic [W-1:0] DEF_P = W'(DEF_PERIOD);
    localparam logic [W-1:0] DEF_H = W'(DEF_PERIOD >> 1);

    logic [W-1:0] cnt;
    logic [W-1:0] act_period;
    logic [W-1:0] act_high;
    logic [W-1:0] sh_period;
    logic [W-1:0] sh_high;
    logic         pend;
    logic         at_end;
    logic         apply_evt;

    // >= rather than ==: an idle apply can shrink the period below the
    // frozen count, and the counter must still fold back to zero.
    assign at_end    = (cnt >= (act_period - W'(1)));
    assign apply_evt = resync | ~en | at_end;

    div_cfg_shadow #(.W(W)) u_shadow (
        .clk       (clk),
        .reset     (reset),
        .cfg       (cfg),
        .apply_evt (apply_evt),
        .pend      (pend),
        .sh_period (sh_period),
        .sh_high   (sh_high)
    );

    // Counter and output compare run on the active values; a pair applied
    // on this edge shapes the next period.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            out  <= 1'b0;
            tick <= 1'b0;
        end else if (resync) begin
            cnt  <= '0;
            out  <= 1'b0;
            tick <= 1'b0;
        end else if (en) begin
            out  <= (cnt < act_high);
            tick <= (cnt == '0);
            cnt  <= at_end ? '0 : (cnt + W'(1));
        end else begin
            tick <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_period <= DEF_P;
            act_high   <= DEF_H;
        end else if (pend && apply_evt) begin
            act_period <= sh_period;
            act_high   <= sh_high;
        end
    end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Self-checking bench for prog_clk_divider: directed scenarios followed by
// randomized traffic, every cycle compared with a behavioural model.
module tb_prog_clk_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, en, resync, out, tick;

    prog_clk_divider_if #(.W(16)) cif ();

    prog_clk_divider #(.W(16), .DEF_PERIOD(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .resync (resync),
        .cfg    (cif.slave),
        .out    (out),
        .tick   (tick)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase within the current period, active P/H,
    // and an optional waiting pair.
    int phase, per, hi, wait_per, wait_hi;
    bit m_out, m_tick, m_pend, m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int  rp, rh, np, nh;
        bit  take, last, use_new;
        rp   = int'(cif.cfg_period);
        rh   = int'(cif.cfg_high);
        take = cif.cfg_valid && !m_pend;
        if (reset) begin
            phase = 0; per = 10; hi = 5;
            m_out = 0; m_tick = 0; m_pend = 0; m_err = 0;
            return;
        end
        last    = (phase >= per - 1);
        use_new = m_pend && (resync || !en || last);
        if (resync) begin
            phase = 0; m_out = 0; m_tick = 0;
        end else if (en) begin
            m_out  = (phase < hi);
            m_tick = (phase == 0);
            phase  = last ? 0 : phase + 1;
        end else begin
            m_tick = 0;
        end
        m_err = 0;
        if (use_new) begin
            per = wait_per; hi = wait_hi; m_pend = 0;
        end
        if (take) begin
            np = (rp < 2) ? 2 : rp;
            nh = (rh == 0 || rh >= np) ? np / 2 : rh;
            wait_per = np; wait_hi = nh; m_pend = 1;
            m_err = (np != rp) || (nh != rh);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("out",   32'(out),           32'(m_out));
        chk("tick",  32'(tick),          32'(m_tick));
        chk("ready", 32'(cif.cfg_ready), 32'(!m_pend));
        chk("err",   32'(cif.cfg_err),   32'(m_err));
    endtask

    task automatic offer(input int p, input int h);
        cif.cfg_valid  = 1'b1;
        cif.cfg_period = 16'(p);
        cif.cfg_high   = 16'(h);
        step();
        cif.cfg_valid  = 1'b0;
    endtask

    task automatic wait_tick(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            seen = tick;
        end
        if (!seen) chk("tick_timeout", 32'(seen), 32'd1);
    endtask

    task automatic wait_ready(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            seen = cif.cfg_ready;
        end
        if (!seen) chk("ready_timeout", 32'(seen), 32'd1);
    endtask

    task automatic count_high(input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (out) highs++;
        end
    endtask

    initial begin
        int highs, ticks;
        reset = 1'b1; en = 1'b1; resync = 1'b0;
        cif.cfg_valid = 1'b0; cif.cfg_period = '0; cif.cfg_high = '0;
        step(); step();
        chk("rst_out",   32'(out),           32'd0);
        chk("rst_tick",  32'(tick),          32'd0);
        chk("rst_ready", 32'(cif.cfg_ready), 32'd1);

        // Defaults: 5 high / 5 low, first tick one cycle after reset drops
        reset = 1'b0;
        step();
        chk("t1_first_out",  32'(out),  32'd1);
        chk("t1_first_tick", 32'(tick), 32'd1);
        highs = 1; ticks = 1;
        for (int i = 0; i < 19; i++) begin
            step();
            if (out)  highs++;
            if (tick) ticks++;
        end
        chk("t1_highs", 32'(highs), 32'd10);
        chk("t1_ticks", 32'(ticks), 32'd2);

        // P=7 H=3 offered mid-period
        step(); step(); step();
        offer(7, 3);
        chk("t2_ready_low", 32'(cif.cfg_ready), 32'd0);
        chk("t2_no_err",    32'(cif.cfg_err),   32'd0);
        wait_ready(20);
        wait_tick(20);
        count_high(6, highs);
        chk("t2_highs", 32'(highs + 1), 32'd3);
        step();
        chk("t2_period", 32'(tick), 32'd1);

        // P=1 H=0 clamps to P=2 H=1
        offer(1, 0);
        chk("t3_err_pulse", 32'(cif.cfg_err), 32'd1);
        step();
        chk("t3_err_once",  32'(cif.cfg_err), 32'd0);
        wait_ready(20);
        wait_tick(20);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_toggle", 32'(out), (i % 2 == 0) ? 32'd0 : 32'd1);
        end

        // P=6 H=9 clamps H to 3; second offer while pending is refused
        cif.cfg_valid = 1'b1; cif.cfg_period = 16'd6; cif.cfg_high = 16'd9;
        step();
        chk("t4_err",       32'(cif.cfg_err),   32'd1);
        chk("t4_ready_low", 32'(cif.cfg_ready), 32'd0);
        cif.cfg_period = 16'd8; cif.cfg_high = 16'd2;
        step();
        cif.cfg_valid = 1'b0;
        wait_ready(20);
        wait_tick(20);
        count_high(5, highs);
        chk("t4_highs", 32'(highs + 1), 32'd3);
        step();
        chk("t4_period", 32'(tick), 32'd1);

        // Back to P=10, then resync at phase 4
        offer(10, 5);
        wait_ready(30);
        wait_tick(30);
        step(); step(); step();
        resync = 1'b1;
        step();
        chk("t5_resync_out",  32'(out),  32'd0);
        chk("t5_resync_tick", 32'(tick), 32'd0);
        resync = 1'b0;
        step();
        chk("t5_restart_out",  32'(out),  32'd1);
        chk("t5_restart_tick", 32'(tick), 32'd1);
        count_high(9, highs);
        chk("t5_highs", 32'(highs + 1), 32'd5);
        step();
        chk("t5_period", 32'(tick), 32'd1);

        // en low for 3 cycles mid-high
        step();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_frozen_out",  32'(out),  32'd1);
            chk("t6_frozen_tick", 32'(tick), 32'd0);
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_resume_high", 32'(out), 32'd1);
        end
        step();
        chk("t6_resume_low", 32'(out), 32'd0);

        // Reset with a pair pending: shadow discarded, defaults back
        offer(4, 1);
        reset = 1'b1;
        step();
        chk("t7_ready", 32'(cif.cfg_ready), 32'd1);
        chk("t7_out",   32'(out),           32'd0);
        reset = 1'b0;
        step();
        chk("t7_tick", 32'(tick), 32'd1);
        count_high(9, highs);
        chk("t7_highs", 32'(highs + 1), 32'd5);
        step();
        chk("t7_period", 32'(tick), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 299) == 0);
            en             = ($urandom_range(0, 9) != 0);
            resync         = ($urandom_range(0, 39) == 0);
            cif.cfg_valid  = ($urandom_range(0, 7) == 0);
            cif.cfg_period = 16'($urandom_range(0, 20));
            cif.cfg_high   = 16'($urandom_range(0, 24));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
